unique0_sel: RTL and testbench
==============================

Name: unique0_sel

Overview:
- N-way "unique0" condition selector: each lane compares an operand against a common threshold and reports which condition is true.
- Zero matching conditions is legal and flagged only as status, not as an error.
- More than one matching condition is a uniqueness violation; it is flagged, counted and resolved by priority, with the lowest index winning, as in an if/else-if chain.
- Sits beside decode/dispatch logic as a registered, checked one-of-N selector.

Parameters:
- WIDTH, 32, operand width in bits (unsigned).
- N, 2, number of condition lanes (2..16).
- THRESH, 30, compare constant; cond[i] = (op[i] > THRESH).
- CNT_W, 16, width of the violation counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid this cycle.
- op  in  N*WIDTH  packed operands, lane i = op[i*WIDTH +: WIDTH].
- viol_clr  in  1  clears viol_sticky and viol_cnt.
- out_valid  out  1  result valid (in_valid delayed 1 cycle).
- match  out  N  one-hot winning lane, or all zero.
- match_idx  out  $clog2(N) (min 1)  index of the winning lane; 0 when none.
- none  out  1  no condition true (legal, informational).
- overlap  out  1  more than one condition true in this result.
- viol_sticky  out  1  set by any overlap since the last clear.
- viol_cnt  out  CNT_W  count of overlap results, saturating.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: all outputs 0.
- Condition compare: combinational, unsigned, strictly greater-than. op == THRESH gives false.
- Priority: the winner is the lowest i with cond[i] = 1. match is one-hot at the winner; match_idx = winner.
- Latency: 1 cycle. On a clock edge with in_valid = 1, register match, match_idx, none and overlap, and set out_valid = 1.
- When in_valid = 0: out_valid goes to 0 and the other result outputs hold their previous values.
- none = 1 exactly when no cond is true. In that case match = 0, match_idx = 0, overlap = 0. No warning and no counter change.
- overlap = 1 exactly when popcount(cond) >= 2.
- On each valid result with overlap: viol_sticky <= 1 and viol_cnt <= viol_cnt + 1, saturating at all-ones (no wrap).
- viol_clr has priority over a simultaneous overlap in the same cycle:
  - viol_sticky <= 0 and viol_cnt <= 0.
  - The overlap result flag itself is still reported.
- Reset mid-operation: all state cleared immediately. The first valid result after reset deasserts is fully fresh.
- Simulation-only assertion (ignored by synthesis): if out_valid && overlap, report an error. No assertion fires for none.

Decomposition:
- Package unique0_pkg:
  - Default constants (WIDTH, THRESH, CNT_W).
  - Function onehot_lowest(vector), returning the lowest set bit as one-hot.
  - Function popcnt_ge2(vector).
- One sub-module is natural: unique0_lane_cmp, a single-operand threshold comparator instantiated N times via generate.
- Priority encode, overlap detect, output registers and counter live in the top.

Test Plan:
- N=2, op0=10, op1=20 -> out_valid=1, none=1, match=00, match_idx=0, overlap=0, viol_cnt=0.
- op0=40, op1=20 -> match=01, match_idx=0, none=0, overlap=0.
- op0=10, op1=40 -> match=10, match_idx=1, overlap=0.
- op0=40, op1=40 -> match=01, match_idx=0, overlap=1, viol_sticky=1, viol_cnt=1. Repeat 3 more times -> viol_cnt=4. Then viol_clr with the same input -> viol_cnt=0, viol_sticky=0, overlap=1.
- Boundary: op0=30, op1=31 -> match=10, match_idx=1. Then op0=30, op1=30 -> none=1.
- Counter saturation: CNT_W=2, drive 5 overlaps -> viol_cnt=3. Then assert rst_n=0 mid-stream -> all outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/unique0_pkg.sv
// unique0_pkg: shared defaults and bit-vector helpers for the unique0 selector.
package unique0_pkg;
  localparam int WIDTH_D  = 32;
  localparam int THRESH_D = 30;
  localparam int CNT_W_D  = 16;
  localparam int MAX_N    = 16;
  function automatic logic [MAX_N-1:0] onehot_lowest(input logic [MAX_N-1:0] v);
    return v & (~v + MAX_N'(1));
  endfunction
  function automatic logic popcnt_ge2(input logic [MAX_N-1:0] v);
    return (v & (v - MAX_N'(1))) != '0;
  endfunction
endpackage

// File: rtl/unique0_lane_cmp.sv
// unique0_lane_cmp: unsigned strict greater-than compare of one operand against a constant.
module unique0_lane_cmp
  import unique0_pkg::*;
#(
  parameter int          WIDTH  = WIDTH_D,
  parameter int unsigned THRESH = THRESH_D
) (
  input  logic [WIDTH-1:0] op,
  output logic             cond
);
  assign cond = op > WIDTH'(THRESH);
endmodule

// File: rtl/unique0_sel.sv
// unique0_sel: registered one-of-N threshold selector with lowest-index priority
// and overlap (uniqueness violation) detection, sticky flag and saturating count.
module unique0_sel
  import unique0_pkg::*;
#(
  parameter int          WIDTH     = WIDTH_D,
  parameter int          N         = 2,
  parameter int unsigned THRESH    = THRESH_D,
  parameter int          CNT_W     = CNT_W_D,
  parameter bit          REPORT_OV = 1'b1,
  localparam int         IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [N*WIDTH-1:0] op,
  input  logic             viol_clr,
  output logic             out_valid,
  output logic [N-1:0]     match,
  output logic [IW-1:0]    match_idx,
  output logic             none,
  output logic             overlap,
  output logic             viol_sticky,
  output logic [CNT_W-1:0] viol_cnt
);
  logic [N-1:0]     cond;
  logic [MAX_N-1:0] cond_w;
  logic [N-1:0]     win;
  logic [IW-1:0]    idx;
  logic             ovl;
  for (genvar g = 0; g < N; g++) begin : g_lane
    unique0_lane_cmp #(.WIDTH(WIDTH), .THRESH(THRESH)) u_cmp (
      .op  (op[g*WIDTH +: WIDTH]),
      .cond(cond[g])
    );
  end
  assign cond_w = MAX_N'(cond);
  assign win    = N'(onehot_lowest(cond_w));
  assign ovl    = popcnt_ge2(cond_w);
  // Scanning downward lets the lowest set lane overwrite any higher one.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (cond[i]) idx = IW'(i);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      match       <= '0;
      match_idx   <= '0;
      none        <= 1'b0;
      overlap     <= 1'b0;
      viol_sticky <= 1'b0;
      viol_cnt    <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        match     <= win;
        match_idx <= idx;
        none      <= ~|cond;
        overlap   <= ovl;
      end
      if (viol_clr) begin
        viol_sticky <= 1'b0;
        viol_cnt    <= '0;
      end else if (in_valid && ovl) begin
        viol_sticky <= 1'b1;
        viol_cnt    <= (&viol_cnt) ? viol_cnt : viol_cnt + CNT_W'(1);
      end
    end
  end
`ifndef SYNTHESIS
  always @(posedge clk)
    if (REPORT_OV && rst_n && out_valid && overlap)
      $error("unique0_sel: more than one condition true, lane %0d chosen", match_idx);
`endif
endmodule

// File: tb/tb_unique0_sel.sv
// tb_unique0_sel: randomized and directed checks of unique0_sel against a lane-scan reference model.
module tb_unique0_sel;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, viol_clr = 1'b0;
  logic [63:0]  op2 = '0;
  logic [159:0] op5 = '0;
  logic v2, n2, o2, s2;  logic [1:0] m2; logic [0:0] i2; logic [15:0] c2;
  logic vs, ns, os, ss;  logic [1:0] ms; logic [0:0] is_; logic [1:0] cs;
  logic v5, n5, o5, s5;  logic [4:0] m5; logic [2:0] i5; logic [2:0] c5;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  unique0_sel #(.N(2), .CNT_W(16), .REPORT_OV(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op2), .viol_clr(viol_clr),
    .out_valid(v2), .match(m2), .match_idx(i2), .none(n2), .overlap(o2),
    .viol_sticky(s2), .viol_cnt(c2));
  unique0_sel #(.N(2), .CNT_W(2), .REPORT_OV(1'b0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op2), .viol_clr(viol_clr),
    .out_valid(vs), .match(ms), .match_idx(is_), .none(ns), .overlap(os),
    .viol_sticky(ss), .viol_cnt(cs));
  unique0_sel #(.N(5), .CNT_W(3), .REPORT_OV(1'b0)) dut_n5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op5), .viol_clr(viol_clr),
    .out_valid(v5), .match(m5), .match_idx(i5), .none(n5), .overlap(o5),
    .viol_sticky(s5), .viol_cnt(c5));
  function automatic void ref_eval(input logic [31:0] o [5], input int n,
                                   output logic [4:0] m, output int idx, output bit nn, output bit ov);
    int c = 0;
    m = '0; idx = 0;
    for (int i = 0; i < n; i++)
      if (o[i] > 32'd30) begin
        if (c == 0) begin m[i] = 1'b1; idx = i; end
        c++;
      end
    nn = (c == 0);
    ov = (c >= 2);
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; viol_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic step2(input logic [31:0] a, input logic [31:0] b, input logic clr);
    @(negedge clk);
    in_valid = 1'b1; viol_clr = clr; op2 = {b, a};
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({v2, m2, i2, n2, o2, s2, c2} !== '0) begin
      errors++;
      $display("FAIL reset: got v=%b m=%b i=%b n=%b o=%b s=%b c=%0d, need all 0", v2, m2, i2, n2, o2, s2, c2);
    end
    do_reset();
  endtask
  task automatic test_basic();
    logic [31:0] vec [5][2] = '{'{10, 20}, '{40, 20}, '{10, 40}, '{30, 31}, '{30, 30}};
    logic [31:0] o [5];
    logic [4:0] m; int idx; bit nn, ov;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step2(vec[k][0], vec[k][1], 1'b0);
      o = '{vec[k][0], vec[k][1], 0, 0, 0};
      ref_eval(o, 2, m, idx, nn, ov);
      checks++;
      if ({v2, m2, i2, n2, o2, s2, c2} !== {1'b1, m[1:0], 1'(idx), nn, ov, 1'b0, 16'd0}) begin
        errors++;
        $display("FAIL basic[%0d] op=%0d,%0d: got v=%b m=%b i=%0d n=%b o=%b s=%b c=%0d, need v=1 m=%b i=%0d n=%b o=%b s=0 c=0",
                 k, vec[k][0], vec[k][1], v2, m2, i2, n2, o2, s2, c2, m[1:0], idx, nn, ov);
      end
    end
  endtask
  task automatic test_overlap();
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      step2(40, 40, 1'b0);
      checks++;
      if ({m2, i2, n2, o2, s2, c2} !== {2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 16'(k)}) begin
        errors++;
        $display("FAIL overlap[%0d]: got m=%b i=%0d n=%b o=%b s=%b c=%0d, need m=01 i=0 n=0 o=1 s=1 c=%0d",
                 k, m2, i2, n2, o2, s2, c2, k);
      end
    end
    step2(40, 40, 1'b1);
    checks++;
    if ({o2, s2, c2} !== {1'b1, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL clr_priority: got o=%b s=%b c=%0d, need o=1 s=0 c=0", o2, s2, c2);
    end
    @(negedge clk);
    in_valid = 1'b0; viol_clr = 1'b0; op2 = {32'd10, 32'd10};
    @(posedge clk);
    #1;
    checks++;
    if ({v2, m2, o2, c2} !== {1'b0, 2'b01, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL idle_hold: got v=%b m=%b o=%b c=%0d, need v=0 m=01 o=1 c=0", v2, m2, o2, c2);
    end
  endtask
  task automatic test_saturation();
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      step2(50, 99, 1'b0);
      checks++;
      if ({ss, cs} !== {1'b1, 2'((k > 3) ? 3 : k)}) begin
        errors++;
        $display("FAIL sat[%0d]: got s=%b c=%0d, need s=1 c=%0d", k, ss, cs, (k > 3) ? 3 : k);
      end
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({vs, ms, is_, ns, os, ss, cs, v2, m2, c2} !== '0) begin
      errors++;
      $display("FAIL async_reset: got sat v=%b m=%b n=%b o=%b s=%b c=%0d main v=%b m=%b c=%0d, need all 0",
               vs, ms, ns, os, ss, cs, v2, m2, c2);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step2(10, 20, 1'b0);
    checks++;
    if ({vs, ms, ns, os, ss, cs} !== {1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL fresh_after_reset: got v=%b m=%b n=%b o=%b s=%b c=%0d, need v=1 m=00 n=1 o=0 s=0 c=0",
               vs, ms, ns, os, ss, cs);
    end
  endtask
  task automatic test_random();
    logic [31:0] o [5];
    logic [4:0] m, em = '0; int idx, ei = 0, ec = 0; bit nn, ov, en = 0, eo = 0, es = 0, ev = 0;
    bit iv, clr;
    do_reset();
    for (int t = 0; t < 300; t++) begin
      iv  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < 5; i++)
        o[i] = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(20, 40));
      @(negedge clk);
      in_valid = iv; viol_clr = clr;
      for (int i = 0; i < 5; i++) op5[i*32 +: 32] = o[i];
      @(posedge clk);
      ref_eval(o, 5, m, idx, nn, ov);
      ev = iv;
      if (iv) begin em = m; ei = idx; en = nn; eo = ov; end
      if (clr) begin ec = 0; es = 0; end
      else if (iv && ov) begin es = 1; ec = (ec == 7) ? 7 : ec + 1; end
      #1;
      checks++;
      if ({v5, m5, i5, n5, o5, s5, c5} !== {ev, em, 3'(ei), en, eo, es, 3'(ec)}) begin
        errors++;
        $display("FAIL random[%0d]: got v=%b m=%b i=%0d n=%b o=%b s=%b c=%0d, need v=%b m=%b i=%0d n=%b o=%b s=%b c=%0d",
                 t, v5, m5, i5, n5, o5, s5, c5, ev, em, ei, en, eo, es, ec);
      end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
